ps2_rx_framer: RTL

- Upstream stage of the per-key watchers. Samples the raw PS/2 keyboard clock and data lines in the system clock domain and deframes the 11-bit PS/2 device-to-host frames.
- On each valid frame it presents the scan-code byte on data and raises flag. All key watchers use flag as their code-change strobe.
- Discards malformed frames, reports them, and resynchronises after a stalled frame.

---
 rtl/ps2_rx_framer.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/ps2_rx_framer.sv
// PS/2 device-to-host receiver: synchronises the raw lines, deframes 11-bit frames
// and presents each good scan-code byte on data with a registered flag strobe.
module ps2_rx_framer #(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 5000,
    parameter int unsigned FLAG_CYCLES    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] data,
    output logic       flag,
    output logic       parity_err,
    output logic       frame_err
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned FLG_W = (FLAG_CYCLES > 1) ? $clog2(FLAG_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   clk_prev;
    logic                   fall_c;
    logic                   sample_c;

    state_t           state, state_nx;
    logic [2:0]       bit_cnt, bit_cnt_nx;
    logic [7:0]       shift_q, shift_nx;
    logic             par_q, par_nx;
    logic [TMO_W-1:0] tmo_cnt, tmo_nx;
    logic             accept_c;
    logic             perr_c;
    logic             ferr_c;

    logic [FLG_W-1:0] flag_cnt;
    logic             flag_pend;

    // Input synchronisers; idle-high reset value avoids a false edge after reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_sync  <= '1;
            data_sync <= '1;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
            clk_prev  <= clk_sync[SYNC_STAGES-1];
        end
    end

    assign fall_c   = clk_prev & ~clk_sync[SYNC_STAGES-1];
    assign sample_c = data_sync[SYNC_STAGES-1];

    // Deframer state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            bit_cnt <= 3'd0;
            shift_q <= 8'd0;
            par_q   <= 1'b0;
            tmo_cnt <= '0;
        end else begin
            state   <= state_nx;
            bit_cnt <= bit_cnt_nx;
            shift_q <= shift_nx;
            par_q   <= par_nx;
            tmo_cnt <= tmo_nx;
        end
    end

    // Next-state logic; a falling edge takes priority over an expiring timeout
    always_comb begin
        state_nx   = state;
        bit_cnt_nx = bit_cnt;
        shift_nx   = shift_q;
        par_nx     = par_q;
        tmo_nx     = tmo_cnt;
        accept_c   = 1'b0;
        perr_c     = 1'b0;
        ferr_c     = 1'b0;

        if (state == IDLE) begin
            tmo_nx = '0;
            if (fall_c && !sample_c) begin
                state_nx   = DATA;
                bit_cnt_nx = 3'd0;
            end
        end else if (fall_c) begin
            tmo_nx = '0;
            case (state)
                DATA: begin
                    shift_nx[bit_cnt] = sample_c;
                    bit_cnt_nx        = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        state_nx = PARITY;
                    end
                end
                PARITY: begin
                    par_nx   = sample_c;
                    state_nx = STOP;
                end
                STOP: begin
                    state_nx = IDLE;
                    if (!sample_c) begin
                        ferr_c = 1'b1;
                    end else if (!(^{shift_q, par_q})) begin
                        perr_c = 1'b1;
                    end else begin
                        accept_c = 1'b1;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end else if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            state_nx = IDLE;
            tmo_nx   = '0;
            ferr_c   = 1'b1;
        end else begin
            tmo_nx = tmo_cnt + TMO_W'(1);
        end
    end

    // Registered outputs; a byte accepted while flag is high forces a one-clock gap
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data       <= 8'd0;
            flag       <= 1'b0;
            flag_cnt   <= '0;
            flag_pend  <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            parity_err <= perr_c;
            frame_err  <= ferr_c;
            if (accept_c) begin
                data <= shift_q;
                if (flag) begin
                    flag      <= 1'b0;
                    flag_pend <= 1'b1;
                end else begin
                    flag      <= 1'b1;
                    flag_pend <= 1'b0;
                    flag_cnt  <= FLG_W'(FLAG_CYCLES - 1);
                end
            end else if (flag_pend) begin
                flag      <= 1'b1;
                flag_pend <= 1'b0;
                flag_cnt  <= FLG_W'(FLAG_CYCLES - 1);
            end else if (flag) begin
                if (flag_cnt == '0) begin
                    flag <= 1'b0;
                end else begin
                    flag_cnt <= flag_cnt - FLG_W'(1);
                end
            end
        end
    end

endmodule
